// File: rtl/level_controller.sv
// rtl/level_controller.sv - per-frame game-state sequencer (level, lives, respawn hold, win/game-over); optional LEVEL_CTRL_LIVES_EN
module level_controller #(
  parameter int         NUM_LEVELS  = 4,
  parameter int         START_LIVES = 3,
  parameter int         HOLD_FRAMES = 30,
  parameter logic [3:0] BG_L0       = 4'h2,
  parameter logic [3:0] BG_L1       = 4'h5,
  parameter logic [3:0] BG_L2       = 4'h8,
  parameter logic [3:0] BG_L3       = 4'hB,
  parameter logic [3:0] FG_L0       = 4'hF,
  parameter logic [3:0] FG_L1       = 4'hE,
  parameter logic [3:0] FG_L2       = 4'hD,
  parameter logic [3:0] FG_L3       = 4'hC
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic       collision,
  input  logic       finish_line_reached,
  input  logic       restart,
  output logic [1:0] current_level,
  output logic [3:0] background,
  output logic [3:0] foreground,
  output logic       reset_player,
  output logic [1:0] lives,
  output logic       game_over,
  output logic       game_won
);

  localparam logic [2:0] ST_PLAY      = 3'd0;
  localparam logic [2:0] ST_HIT       = 3'd1;
  localparam logic [2:0] ST_ADVANCE   = 3'd2;
  localparam logic [2:0] ST_GAME_OVER = 3'd3;
  localparam logic [2:0] ST_WIN       = 3'd4;

  localparam logic [1:0] LAST_LEVEL = 2'(NUM_LEVELS - 1);
  localparam logic [1:0] INIT_LIVES = 2'(START_LIVES);
  localparam logic [5:0] HOLD_LOAD  = 6'(HOLD_FRAMES - 1);

  logic       frame_clk_prev_q;
  logic       frame_tick;
  logic [2:0] state_q, state_d;
  logic [1:0] level_q, level_d;
  logic [5:0] hold_cnt_q, hold_cnt_d;
  logic       reset_player_q, reset_player_d;
  logic [3:0] background_q, background_d;
  logic [3:0] foreground_q, foreground_d;
`ifdef LEVEL_CTRL_LIVES_EN
  logic [1:0] lives_q, lives_d;
  logic [1:0] lives_dec;
`endif

  function automatic logic [3:0] bg_lookup(input logic [1:0] lvl);
    case (lvl)
      2'd0:    return BG_L0;
      2'd1:    return BG_L1;
      2'd2:    return BG_L2;
      default: return BG_L3;
    endcase
  endfunction

  function automatic logic [3:0] fg_lookup(input logic [1:0] lvl);
    case (lvl)
      2'd0:    return FG_L0;
      2'd1:    return FG_L1;
      2'd2:    return FG_L2;
      default: return FG_L3;
    endcase
  endfunction

  // Next-state logic: every decision is gated by the one-cycle frame tick
  always_comb begin
    frame_tick = frame_clk & ~frame_clk_prev_q;
    state_d    = state_q;
    level_d    = level_q;
    hold_cnt_d = hold_cnt_q;
`ifdef LEVEL_CTRL_LIVES_EN
    lives_d    = lives_q;
    lives_dec  = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
`endif
    if (frame_tick) begin
      case (state_q)
        ST_PLAY: begin
          // collision takes priority over a simultaneous finish
          if (collision) begin
`ifdef LEVEL_CTRL_LIVES_EN
            lives_d = lives_dec;
            if (lives_dec == 2'd0) begin
              state_d = ST_GAME_OVER;
            end else begin
              state_d    = ST_HIT;
              hold_cnt_d = HOLD_LOAD;
            end
`else
            state_d    = ST_HIT;
            hold_cnt_d = HOLD_LOAD;
`endif
          end else if (finish_line_reached) begin
            if (level_q >= LAST_LEVEL) begin
              state_d = ST_WIN;
            end else begin
              state_d    = ST_ADVANCE;
              level_d    = level_q + 2'd1;
              hold_cnt_d = HOLD_LOAD;
            end
          end
        end
        ST_HIT, ST_ADVANCE: begin
          // flags are ignored while the player is held at spawn
          if (hold_cnt_q == 6'd0) begin
            state_d = ST_PLAY;
          end else begin
            hold_cnt_d = hold_cnt_q - 6'd1;
          end
        end
        ST_GAME_OVER, ST_WIN: begin
          if (restart) begin
            state_d    = ST_PLAY;
            level_d    = 2'd0;
            hold_cnt_d = 6'd0;
`ifdef LEVEL_CTRL_LIVES_EN
            lives_d    = INIT_LIVES;
`endif
          end
        end
        default: begin
          state_d    = ST_PLAY;
          hold_cnt_d = 6'd0;
        end
      endcase
    end
    reset_player_d = (state_d != ST_PLAY);
    background_d   = bg_lookup(level_d);
    foreground_d   = fg_lookup(level_d);
  end

  // State registers; reset holds the ball at spawn for one cycle
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      frame_clk_prev_q <= 1'b0;
      state_q          <= ST_PLAY;
      level_q          <= 2'd0;
      hold_cnt_q       <= 6'd0;
      reset_player_q   <= 1'b1;
      background_q     <= BG_L0;
      foreground_q     <= FG_L0;
`ifdef LEVEL_CTRL_LIVES_EN
      lives_q          <= INIT_LIVES;
`endif
    end else begin
      frame_clk_prev_q <= frame_clk;
      state_q          <= state_d;
      level_q          <= level_d;
      hold_cnt_q       <= hold_cnt_d;
      reset_player_q   <= reset_player_d;
      background_q     <= background_d;
      foreground_q     <= foreground_d;
`ifdef LEVEL_CTRL_LIVES_EN
      lives_q          <= lives_d;
`endif
    end
  end

  assign current_level = level_q;
  assign background    = background_q;
  assign foreground    = foreground_q;
  assign reset_player  = reset_player_q;
  assign game_won      = (state_q == ST_WIN);
`ifdef LEVEL_CTRL_LIVES_EN
  assign lives         = lives_q;
  assign game_over     = (state_q == ST_GAME_OVER);
`else
  assign lives         = INIT_LIVES;
  assign game_over     = 1'b0;
`endif

endmodule

// File: tb/tb_level_controller.sv
// tb/tb_level_controller.sv - scoreboard bench for level_controller
module tb_level_controller;

`ifdef LEVEL_CTRL_LIVES_EN
  localparam bit LIVES_EN = 1'b1;
`else
  localparam bit LIVES_EN = 1'b0;
`endif

  typedef struct packed {
    logic [1:0] lvl;
    logic [3:0] bg;
    logic [3:0] fg;
    logic       rp;
    logic [1:0] lv;
    logic       go;
    logic       won;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_clk = 1'b0;
  logic       collision = 1'b0;
  logic       finish = 1'b0;
  logic       restart = 1'b0;
  logic [1:0] current_level;
  logic [3:0] background;
  logic [3:0] foreground;
  logic       reset_player;
  logic [1:0] lives;
  logic       game_over;
  logic       game_won;

  int   checks = 0;
  int   errors = 0;
  int   tick_id = 0;
  exp_t exp_q[$];
  logic fc_prev = 1'b0;
  logic pending = 1'b0;

  level_controller dut (
    .Clk                 (clk),
    .Reset_n             (rst_n),
    .frame_clk           (frame_clk),
    .collision           (collision),
    .finish_line_reached (finish),
    .restart             (restart),
    .current_level       (current_level),
    .background          (background),
    .foreground          (foreground),
    .reset_player        (reset_player),
    .lives               (lives),
    .game_over           (game_over),
    .game_won            (game_won)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] bg_of(input logic [1:0] l);
    case (l)
      2'd0: return 4'h2;
      2'd1: return 4'h5;
      2'd2: return 4'h8;
      default: return 4'hB;
    endcase
  endfunction

  function automatic logic [3:0] fg_of(input logic [1:0] l);
    case (l)
      2'd0: return 4'hF;
      2'd1: return 4'hE;
      2'd2: return 4'hD;
      default: return 4'hC;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Flag a tick edge so the monitor samples half a cycle later
  always @(posedge clk) begin
    pending <= rst_n && frame_clk && !fc_prev;
    fc_prev <= rst_n ? frame_clk : 1'b0;
  end

  // Monitor: compare DUT outputs after each tick against the scoreboard
  always @(negedge clk) begin
    exp_t act, e;
    if (pending) begin
      act = {current_level, background, foreground, reset_player, lives, game_over, game_won};
      tick_id++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL tick%0d: got %h with no expected entry", tick_id, act);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          errors++;
          $display("FAIL tick%0d: got lvl=%0d bg=%h fg=%h rp=%b lives=%0d go=%b won=%b expected lvl=%0d bg=%h fg=%h rp=%b lives=%0d go=%b won=%b",
                   tick_id, act.lvl, act.bg, act.fg, act.rp, act.lv, act.go, act.won,
                   e.lvl, e.bg, e.fg, e.rp, e.lv, e.go, e.won);
        end
      end
    end
  end

  task automatic tick(input logic c, input logic f, input logic r, input logic [1:0] lvl,
                      input logic rp, input logic [1:0] lv, input logic go, input logic won);
    exp_t e;
    e = {lvl, bg_of(lvl), fg_of(lvl), rp, lv, go, won};
    @(negedge clk);
    frame_clk = 1'b1; collision = c; finish = f; restart = r;
    exp_q.push_back(e);
    @(negedge clk);
    frame_clk = 1'b0; collision = 1'b0; finish = 1'b0; restart = 1'b0;
  endtask

  // 29 held ticks, then the tick that returns to PLAY
  task automatic hold_release(input logic [1:0] lvl, input logic [1:0] lv);
    repeat (29) tick(1'b0, 1'b0, 1'b0, lvl, 1'b1, lv, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, lvl, 1'b0, lv, 1'b0, 1'b0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_player_drop", reset_player, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] l3;
    l3 = LIVES_EN ? 2'd2 : 2'd3;

    // 1. reset values while reset is held
    repeat (2) @(negedge clk);
    check("rst_level", current_level, 2'd0);
    check("rst_bg", background, 4'h2);
    check("rst_fg", foreground, 4'hF);
    check("rst_rp", reset_player, 1'b1);
    check("rst_lives", lives, 2'd3);
    check("rst_go", game_over, 1'b0);
    check("rst_won", game_won, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rp_first_edge", reset_player, 1'b0);
    repeat (3) tick(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd3, 1'b0, 1'b0);

    // flags between ticks are ignored
    @(negedge clk);
    collision = 1'b1; finish = 1'b1;
    @(negedge clk);
    collision = 1'b0; finish = 1'b0;
    tick(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd3, 1'b0, 1'b0);

    // 2. level-up with 30-tick hold; collision during hold is ignored
    tick(1'b0, 1'b1, 1'b0, 2'd1, 1'b1, 2'd3, 1'b0, 1'b0);
    for (int i = 1; i <= 29; i++)
      tick(i == 5, i == 7, 1'b0, 2'd1, 1'b1, 2'd3, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 2'd3, 1'b0, 1'b0);

    // 3. collision beats finish
    tick(1'b1, 1'b1, 1'b0, 2'd1, 1'b1, l3, 1'b0, 1'b0);
    hold_release(2'd1, l3);

    // 4. lives run-out and restart
    apply_reset();
    if (LIVES_EN) begin
      tick(1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 2'd2, 1'b0, 1'b0);
      hold_release(2'd0, 2'd2);
      tick(1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 2'd1, 1'b0, 1'b0);
      hold_release(2'd0, 2'd1);
      tick(1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 2'd0, 1'b1, 1'b0);
      tick(1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 2'd0, 1'b1, 1'b0);
      tick(1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 2'd3, 1'b0, 1'b0);
    end else begin
      for (int k = 0; k < 5; k++) begin
        tick(1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 2'd3, 1'b0, 1'b0);
        hold_release(2'd0, 2'd3);
      end
    end

    // 5. walk to WIN, flags ignored afterwards, restart
    apply_reset();
    tick(1'b0, 1'b1, 1'b0, 2'd1, 1'b1, 2'd3, 1'b0, 1'b0);
    hold_release(2'd1, 2'd3);
    tick(1'b0, 1'b1, 1'b0, 2'd2, 1'b1, 2'd3, 1'b0, 1'b0);
    hold_release(2'd2, 2'd3);
    tick(1'b0, 1'b1, 1'b0, 2'd3, 1'b1, 2'd3, 1'b0, 1'b0);
    hold_release(2'd3, 2'd3);
    tick(1'b0, 1'b1, 1'b0, 2'd3, 1'b1, 2'd3, 1'b0, 1'b1);
    tick(1'b1, 1'b1, 1'b0, 2'd3, 1'b1, 2'd3, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 2'd3, 1'b0, 1'b0);

    // 6. reset mid-hold (hold_cnt=10) returns everything to reset values
    tick(1'b0, 1'b1, 1'b0, 2'd1, 1'b1, 2'd3, 1'b0, 1'b0);
    repeat (19) tick(1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 2'd3, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midhold_level", current_level, 2'd0);
    check("midhold_bg", background, 4'h2);
    check("midhold_rp", reset_player, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midhold_rp_drop", reset_player, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd3, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 2'd1, 1'b1, 2'd3, 1'b0, 1'b0);
    hold_release(2'd1, 2'd3);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
